// File: rtl/key_press_gen.sv
// key_press_gen: keypad emulator. Takes BCD key codes over valid/ready and replays
// each one as a timed active-low one-hot press on S_n, followed by an all-released gap.
// Optional code FIFO in front of the FSM is enabled by defining KEY_FIFO_EN.
module key_press_gen #(
  parameter int PRESS_CYC  = 4,
  parameter int GAP_CYC    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] code_i,
  input  logic       code_valid,
  output logic       code_ready,
  output logic [9:0] S_n,
  output logic       busy,
  output logic       err
);

  localparam int CNT_MAX = (PRESS_CYC > GAP_CYC) ? PRESS_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_PRESS = CNT_W'(PRESS_CYC);
  localparam logic [CNT_W-1:0] CNT_GAP   = CNT_W'(GAP_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, PRESS = 2'd1, GAP = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       code_q, code_nxt;
  logic             src_avail;
  logic [3:0]       src_code;
  logic             at_end, can_take, take, take_ok;
  logic [9:0]       sn_nxt;
  logic             busy_nxt, err_nxt;

`ifdef KEY_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_DEPTH - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fcount, fcount_nxt;
  logic          push, pop;

  // The FSM consumes codes from the FIFO head; range check happens at pop
  assign code_ready = (fcount != CNT_FULL);
  assign push       = code_valid & code_ready;
  assign pop        = take;
  assign src_avail  = (fcount != '0);
  assign src_code   = mem[rd_ptr];

  // FIFO occupancy for the next cycle
  always_comb begin
    fcount_nxt = fcount;
    if (push && !pop)
      fcount_nxt = fcount + 1'b1;
    else if (!push && pop)
      fcount_nxt = fcount - 1'b1;
  end

  // FIFO pointers and occupancy; reset flushes any queued codes
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcount <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      fcount <= fcount_nxt;
    end
  end

  // FIFO storage (data only)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= code_i;
  end
`else
  // Without a FIFO the handshake itself is the code source, accepted only in IDLE
  assign code_ready = (state == IDLE);
  assign src_avail  = code_valid & code_ready;
  assign src_code   = code_i;
`endif

  // State register and press/gap down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Code of the press in flight (data only)
  always_ff @(posedge clk) begin
    code_q <= code_nxt;
  end

  // Next-state logic; a new code may start a press in IDLE or on the last cycle
  // of GAP (of PRESS when there is no gap), so back-to-back codes lose no cycle
  always_comb begin
    at_end    = (cnt == CNT_ONE);
    can_take  = (state == IDLE) || (state == GAP && at_end) ||
                (state == PRESS && at_end && GAP_CYC == 0);
    take      = can_take && src_avail;
    take_ok   = take && (src_code <= 4'd9);
    state_nxt = state;
    cnt_nxt   = cnt;
    code_nxt  = code_q;
    case (state)
      IDLE: begin
        if (take_ok) begin
          state_nxt = PRESS;
          cnt_nxt   = CNT_PRESS;
          code_nxt  = src_code;
        end
      end
      PRESS: begin
        if (!at_end) begin
          cnt_nxt = cnt - 1'b1;
        end else if (GAP_CYC != 0) begin
          state_nxt = GAP;
          cnt_nxt   = CNT_GAP;
        end else if (take_ok) begin
          state_nxt = PRESS;
          cnt_nxt   = CNT_PRESS;
          code_nxt  = src_code;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      GAP: begin
        if (!at_end) begin
          cnt_nxt = cnt - 1'b1;
        end else if (take_ok) begin
          state_nxt = PRESS;
          cnt_nxt   = CNT_PRESS;
          code_nxt  = src_code;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output values for the next cycle, derived from the next state
  always_comb begin
    sn_nxt = 10'h3FF;
    if (state_nxt == PRESS) sn_nxt = ~(10'd1 << code_nxt);
    err_nxt  = take && !take_ok;
`ifdef KEY_FIFO_EN
    busy_nxt = (state_nxt != IDLE) || (fcount_nxt != '0);
`else
    busy_nxt = (state_nxt != IDLE);
`endif
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      S_n  <= 10'h3FF;
      busy <= 1'b0;
      err  <= 1'b0;
    end else begin
      S_n  <= sn_nxt;
      busy <= busy_nxt;
      err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_key_press_gen.sv
// Testbench for key_press_gen: table-driven codes through a scoreboard plus
// directed timing sequences (latency, invalid code, reset mid-press, no-gap DUT).
`timescale 1ns/1ps
module tb_key_press_gen;
  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] code_i;
  logic       code_valid;
  logic       code_ready;
  logic [9:0] S_n;
  logic       busy, err;
  logic [3:0] code_b;
  logic       valid_b, ready_b;
  logic [9:0] sn_b;
  logic       busy_b, err_b;

  always #5 clk = ~clk;

  key_press_gen #(.PRESS_CYC(4), .GAP_CYC(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .code_i(code_i), .code_valid(code_valid),
    .code_ready(code_ready), .S_n(S_n), .busy(busy), .err(err));

  key_press_gen #(.PRESS_CYC(4), .GAP_CYC(0), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .code_i(code_b), .code_valid(valid_b),
    .code_ready(ready_b), .S_n(sn_b), .busy(busy_b), .err(err_b));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct { logic is_err; logic [9:0] sn; } exp_t;
  typedef struct { logic [3:0] code; logic exp_err; logic [9:0] exp_sn; } vec_t;

  exp_t sbq[$];
  int   starts[$];
  exp_t mon_e;
  vec_t vecs[12];

  logic [9:0] t2_sn   [1:7]  = '{10'h37F, 10'h37F, 10'h37F, 10'h37F, 10'h3FF, 10'h3FF, 10'h3FF};
  logic       t2_busy [1:7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       t2_rdy  [1:7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [9:0] b_sn    [1:10] = '{10'h1FF, 10'h1FF, 10'h1FF, 10'h1FF, 10'h3FF,
                                 10'h3FE, 10'h3FE, 10'h3FE, 10'h3FE, 10'h3FF};
  logic       b_rdy   [1:10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       b_busy  [1:10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [9:0] f_sn    [6]    = '{10'h3FD, 10'h3FB, 10'h3F7, 10'h3EF, 10'h3DF, 10'h3BF};

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: event not expected or not seen (cycle %0d)", nm, cyc);
  endtask

  // Output monitor: pops the scoreboard on every press start or err pulse
  logic       mon_en = 1'b0;
  logic [9:0] prev_sn = 10'h3FF;
  int         run_len = 0;
  bit         run_aborted = 1'b0;

  always @(posedge clk) if (rst) run_aborted = 1'b1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (err === 1'b1) begin
        if (sbq.size() == 0) fail_now("sb_err_unexpected");
        else begin
          mon_e = sbq.pop_front();
          chk("sb_kind_err", 32'(mon_e.is_err), 32'd1);
        end
      end
      if (S_n !== 10'h3FF && prev_sn === 10'h3FF) begin
        starts.push_back(cyc);
        if (sbq.size() == 0) fail_now("sb_press_unexpected");
        else begin
          mon_e = sbq.pop_front();
          chk("sb_kind_press", 32'(mon_e.is_err), 32'd0);
          chk("sb_sn", 32'(S_n), 32'(mon_e.sn));
        end
        run_len = 1;
        run_aborted = 1'b0;
      end else if (S_n !== 10'h3FF) begin
        chk("press_stable", 32'(S_n), 32'(prev_sn));
        run_len++;
      end else if (prev_sn !== 10'h3FF) begin
        if (!run_aborted) chk("press_len", run_len, P);
      end
      prev_sn = S_n;
    end
  end

  task automatic send(input logic [3:0] c, input logic e, input logic [9:0] sn);
    int n;
    n = 0;
    code_i = c;
    code_valid = 1'b1;
    while (code_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (code_ready !== 1'b1) fail_now("send_timeout");
    else sbq.push_back('{e, sn});
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || busy !== 1'b0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_sb_empty", sbq.size(), 0);
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_sn", 32'(S_n), 32'h3FF);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_seen;
    vecs[0]  = '{4'd0, 1'b0, 10'h3FE};
    vecs[1]  = '{4'd1, 1'b0, 10'h3FD};
    vecs[2]  = '{4'd2, 1'b0, 10'h3FB};
    vecs[3]  = '{4'd3, 1'b0, 10'h3F7};
    vecs[4]  = '{4'hA, 1'b1, 10'h3FF};
    vecs[5]  = '{4'd4, 1'b0, 10'h3EF};
    vecs[6]  = '{4'd5, 1'b0, 10'h3DF};
    vecs[7]  = '{4'd6, 1'b0, 10'h3BF};
    vecs[8]  = '{4'hF, 1'b1, 10'h3FF};
    vecs[9]  = '{4'd7, 1'b0, 10'h37F};
    vecs[10] = '{4'd8, 1'b0, 10'h2FF};
    vecs[11] = '{4'd9, 1'b0, 10'h1FF};

    rst = 1'b1; code_i = '0; code_valid = 1'b0; code_b = '0; valid_b = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sn", 32'(S_n), 32'h3FF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(code_ready), 32'd1);
    chk("rst_b_sn", 32'(sn_b), 32'h3FF);
    prev_sn = 10'h3FF;
    mon_en = 1'b1;

`ifndef KEY_FIFO_EN
    // Code 7: press latency, press/gap lengths, busy and ready timing
    code_i = 4'd7; code_valid = 1'b1;
    chk("t2_ready_idle", 32'(code_ready), 32'd1);
    sbq.push_back('{1'b0, 10'h37F});
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) code_valid = 1'b0;
      chk("t2_sn", 32'(S_n), 32'(t2_sn[k]));
      chk("t2_busy", 32'(busy), 32'(t2_busy[k]));
      chk("t2_ready", 32'(code_ready), 32'(t2_rdy[k]));
    end

    // Invalid code: one-cycle err, no press, stays idle
    code_i = 4'hC; code_valid = 1'b1;
    sbq.push_back('{1'b1, 10'h3FF});
    @(negedge clk);
    code_valid = 1'b0;
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_sn", 32'(S_n), 32'h3FF);
    chk("t3_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t3_err_clear", 32'(err), 32'd0);
    chk("t3_ready", 32'(code_ready), 32'd1);

    // Back-to-back codes: press starts PRESS+GAP+1 cycles apart
    starts.delete();
    send(4'd2, 1'b0, 10'h3FB);
    send(4'd3, 1'b0, 10'h3F7);
    repeat (2) @(negedge clk);
    if (starts.size() != 2) fail_now("period_starts");
    else chk("period", starts[1] - starts[0], 7);
    drain();

    // Reset on the 2nd press cycle of code 0
    code_i = 4'd0; code_valid = 1'b1;
    sbq.push_back('{1'b0, 10'h3FE});
    @(negedge clk);
    code_valid = 1'b0;
    chk("t4_press", 32'(S_n), 32'h3FE);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_sn", 32'(S_n), 32'h3FF);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_ready", 32'(code_ready), 32'd1);
    chk("t4_err", 32'(err), 32'd0);

    // No-gap instance: 9 then 0, one IDLE cycle between, ready low while pressing
    code_b = 4'd9; valid_b = 1'b1;
    chk("t6_ready0", 32'(ready_b), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) code_b = 4'd0;
      chk("t6_sn", 32'(sn_b), 32'(b_sn[k]));
      chk("t6_ready", 32'(ready_b), 32'(b_rdy[k]));
      chk("t6_busy", 32'(busy_b), 32'(b_busy[k]));
      chk("t6_err", 32'(err_b), 32'd0);
      if (k == 6) valid_b = 1'b0;
    end
`endif

    // Table of codes, valid and invalid, checked through the scoreboard
    for (int i = 0; i < 12; i++) send(vecs[i].code, vecs[i].exp_err, vecs[i].exp_sn);
    drain();

`ifdef KEY_FIFO_EN
    // Codes pushed on consecutive cycles: FIFO fills and stalls, presses in order
    starts.delete();
    stall_seen = 0;
    for (int i = 1; i <= 6; i++) begin
      code_i = 4'(i); code_valid = 1'b1;
      for (int n = 0; n < 200 && code_ready !== 1'b1; n++) begin
        stall_seen = 1;
        @(negedge clk);
      end
      sbq.push_back('{1'b0, f_sn[i-1]});
      @(negedge clk);
    end
    code_valid = 1'b0;
    chk("t5_stall", stall_seen, 1);
    drain();
    if (starts.size() != 6) fail_now("t5_starts");
    else for (int i = 1; i < 6; i++) chk("t5_period", starts[i] - starts[i-1], 6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
